mips_lsu: RTL
=============

Name: mips_lsu

Overview:
Multi-cycle load/store unit between the MIPS core datapath and the real-memory request/response channels. It owns the Mem_Req_Ack and Read_data_Valid handshakes and holds requests stable across memory stalls. It does all byte-lane alignment for LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW/SWL/SWR, rejects misaligned accesses, and counts load/store/stall activity for the perf-counter outputs.

Parameters:
ADDR_W, 32, byte-address width of core and memory address.
CNT_W, 32, width of each performance counter.
CHECK_ALIGN, 1, 1 = misaligned LH/LHU/SH/LW/SW reported as error with no memory access; 0 = address low bits ignored.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  core presents an access
req_ready  out  1  high only in IDLE; accept = req_valid & req_ready
req_op  in  4  access type, LSU_OP_* encoding
req_addr  in  ADDR_W  byte address (base + offset)
req_rt  in  32  rt register value (store data / LWL-LWR merge source)
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  extended/merged load result; 0 for stores and errors
resp_err  out  1  misaligned access, valid with resp_valid
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_read  out  1  load request
mem_write  out  1  store request
mem_wdata  out  32  lane-positioned store data
mem_wstrb  out  4  byte strobes
mem_req_ack  in  1  memory accepts the request
mem_rdata  in  32  read data
mem_rdata_valid  in  1  read data valid
mem_rdata_ack  out  1  LSU ready for read data
cnt_load  out  CNT_W  completed loads
cnt_store  out  CNT_W  completed stores
cnt_stall  out  CNT_W  cycles spent in REQ or RESP

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. State IDLE. All outputs 0 except req_ready=1. Counters 0. Reset mid-transaction abandons it: no resp_valid, memory strobes drop the next cycle.
- FSM: IDLE, REQ, RESP, DONE.
- IDLE: on accept, register op/addr/rt. If CHECK_ALIGN and misaligned (H ops addr[0]!=0; LW/SW addr[1:0]!=0), go to DONE with err=1. Otherwise go to REQ.
- REQ: mem_read or mem_write held high with mem_addr/mem_wdata/mem_wstrb stable until mem_req_ack. On ack a load goes to RESP and a store goes to DONE. Ack in the same cycle REQ is entered is legal.
- RESP: mem_rdata_ack=1. On mem_rdata_valid, capture the aligned/merged result and go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready is low here, so back-to-back accesses have one idle-turnaround cycle.
- Minimum latency with accept in cycle 0 and zero-wait memory: store resp_valid in cycle 2, load in cycle 3, error in cycle 1.
- Load extraction uses little-endian lanes, b = addr[1:0]:
  - LB/LBU: byte b, sign/zero extended.
  - LH/LHU: half addr[1], sign/zero extended.
  - LWL: b=0 {rd[7:0],rt[23:0]}; 1 {rd[15:0],rt[15:0]}; 2 {rd[23:0],rt[7:0]}; 3 rd.
  - LWR: 0 rd; 1 {rt[31:24],rd[31:8]}; 2 {rt[31:16],rd[31:16]}; 3 {rt[31:8],rd[31:24]}.
- Store strobes:
  - SB: 1<<b.
  - SH: addr[1] ? 4'b1100 : 4'b0011.
  - SW: 4'hF.
  - SWL for b=0..3: 1,3,7,F.
  - SWR for b=0..3: F,E,C,8.
- Store data: replicated/shifted so the strobed lanes carry the correct rt bytes; unstrobed lanes are don't-care but driven deterministically.
- Unknown req_op: treated as error, no memory access.
- Counters:
  - cnt_load/cnt_store increment in the DONE cycle of non-error completions.
  - cnt_stall increments every cycle in REQ or RESP.
  - All counters wrap modulo 2^CNT_W.
- mem_rdata_valid outside RESP and mem_req_ack outside REQ are ignored.

Decomposition:
- Package mips_lsu_pkg: LSU_OP_LB..LSU_OP_SWR constants (LB=0, LH=1, LW=2, LBU=3, LHU=4, LWL=5, LWR=6, SB=7, SH=8, SW=9, SWL=10, SWR=11); state encoding; is_load/is_store helper functions.
- Sub-module lsu_align: purely combinational (op, addr[1:0], rt, rdata) -> (load result, wdata, wstrb, misaligned). The FSM and counters stay in mips_lsu.

Test Plan:
- LB addr 0x103, mem_rdata 0x80112233, ack immediate, valid next cycle -> resp_data 0xFFFFFF80, resp_valid 3 cycles after accept, cnt_load=1.
- SH addr 0x202, rt 0x0000BEEF, mem_req_ack delayed 4 cycles -> mem_write, mem_addr 0x200, mem_wstrb 1100 and mem_wdata[31:16]=0xBEEF all stable for 5 cycles; cnt_stall=5.
- LWL addr 0x1, rt 0xAABBCCDD, rdata 0x11223344 -> resp_data 0x3344CCDD. LWR addr 0x2, same data -> 0xAABB1122.
- LW addr 0x6 with CHECK_ALIGN=1 -> no mem_read, resp_valid+resp_err the cycle after accept, resp_data 0, counters unchanged.
- SWR addr 0x3, rt 0x12345678 -> mem_wstrb 1000, mem_wdata[31:24]=0x78.
- Load stalled in RESP, rst asserted -> next cycle IDLE, req_ready=1, no resp_valid, counters 0; a new SW then completes normally.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: op encodings, FSM states
// and op-class helpers.
package mips_lsu_pkg;

  localparam logic [3:0] LSU_OP_LB  = 4'd0;
  localparam logic [3:0] LSU_OP_LH  = 4'd1;
  localparam logic [3:0] LSU_OP_LW  = 4'd2;
  localparam logic [3:0] LSU_OP_LBU = 4'd3;
  localparam logic [3:0] LSU_OP_LHU = 4'd4;
  localparam logic [3:0] LSU_OP_LWL = 4'd5;
  localparam logic [3:0] LSU_OP_LWR = 4'd6;
  localparam logic [3:0] LSU_OP_SB  = 4'd7;
  localparam logic [3:0] LSU_OP_SH  = 4'd8;
  localparam logic [3:0] LSU_OP_SW  = 4'd9;
  localparam logic [3:0] LSU_OP_SWL = 4'd10;
  localparam logic [3:0] LSU_OP_SWR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return op <= LSU_OP_LWR;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= LSU_OP_SB) && (op <= LSU_OP_SWR);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction/merge, store lane placement,
// store strobes and alignment checking for one access.
module lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic        bad_op
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // LWL/LWR merge the addressed memory bytes into the matching end of rt.
  always_comb begin
    load_data = 32'd0;
    case (op)
      LSU_OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_OP_LBU: load_data = {24'd0, byte_sel};
      LSU_OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LSU_OP_LHU: load_data = {16'd0, half_sel};
      LSU_OP_LW:  load_data = rdata;
      LSU_OP_LWL: begin
        case (addr_lo)
          2'd0: load_data = {rdata[7:0], rt[23:0]};
          2'd1: load_data = {rdata[15:0], rt[15:0]};
          2'd2: load_data = {rdata[23:0], rt[7:0]};
          default: load_data = rdata;
        endcase
      end
      LSU_OP_LWR: begin
        case (addr_lo)
          2'd0: load_data = rdata;
          2'd1: load_data = {rt[31:24], rdata[31:8]};
          2'd2: load_data = {rt[31:16], rdata[31:16]};
          default: load_data = {rt[31:8], rdata[31:24]};
        endcase
      end
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    wdata = 32'd0;
    wstrb = 4'b0000;
    case (op)
      LSU_OP_SB: begin
        wdata = {4{rt[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      LSU_OP_SH: begin
        wdata = {2{rt[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      LSU_OP_SW: begin
        wdata = rt;
        wstrb = 4'b1111;
      end
      LSU_OP_SWL: begin
        case (addr_lo)
          2'd0: begin wdata = {24'd0, rt[31:24]}; wstrb = 4'b0001; end
          2'd1: begin wdata = {16'd0, rt[31:16]}; wstrb = 4'b0011; end
          2'd2: begin wdata = {8'd0, rt[31:8]};   wstrb = 4'b0111; end
          default: begin wdata = rt;              wstrb = 4'b1111; end
        endcase
      end
      LSU_OP_SWR: begin
        case (addr_lo)
          2'd0: begin wdata = rt;                 wstrb = 4'b1111; end
          2'd1: begin wdata = {rt[23:0], 8'd0};   wstrb = 4'b1110; end
          2'd2: begin wdata = {rt[15:0], 16'd0};  wstrb = 4'b1100; end
          default: begin wdata = {rt[7:0], 24'd0}; wstrb = 4'b1000; end
        endcase
      end
      default: begin
        wdata = 32'd0;
        wstrb = 4'b0000;
      end
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (op)
      LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: misaligned = addr_lo[0];
      LSU_OP_LW, LSU_OP_SW:             misaligned = |addr_lo;
      default:                          misaligned = 1'b0;
    endcase
    bad_op = !(is_load(op) || is_store(op));
  end

endmodule

// File: rtl/mips_lsu.sv
// Multi-cycle MIPS load/store unit: request/response handshakes with memory,
// alignment checking and load/store/stall performance counters.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32,
  parameter int CHECK_ALIGN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_rt,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_req_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              mem_rdata_ack,
  output logic [CNT_W-1:0]  cnt_load,
  output logic [CNT_W-1:0]  cnt_store,
  output logic [CNT_W-1:0]  cnt_stall
);

  lsu_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       rt_q, rt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              mem_rdata_ack_q, mem_rdata_ack_d;
  logic [CNT_W-1:0]  cnt_load_q, cnt_load_d;
  logic [CNT_W-1:0]  cnt_store_q, cnt_store_d;
  logic [CNT_W-1:0]  cnt_stall_q, cnt_stall_d;

  logic        sel_idle;
  logic [3:0]  al_op;
  logic [1:0]  al_addr_lo;
  logic [31:0] al_rt;
  logic [31:0] al_load_data;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic        al_misaligned;
  logic        al_bad_op;
  logic        acc_err;

  // One aligner serves both phases: incoming request while idle, latched access afterwards.
  assign sel_idle   = (state_q == ST_IDLE);
  assign al_op      = sel_idle ? req_op : op_q;
  assign al_addr_lo = sel_idle ? req_addr[1:0] : addr_lo_q;
  assign al_rt      = sel_idle ? req_rt : rt_q;
  assign acc_err    = al_bad_op || ((CHECK_ALIGN != 0) && al_misaligned);

  lsu_align u_align (
    .op         (al_op),
    .addr_lo    (al_addr_lo),
    .rt         (al_rt),
    .rdata      (mem_rdata),
    .load_data  (al_load_data),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (al_misaligned),
    .bad_op     (al_bad_op)
  );

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_lo_d       = addr_lo_q;
    rt_d            = rt_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_data_d     = 32'd0;
    resp_err_d      = 1'b0;
    mem_addr_d      = '0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_wdata_d     = 32'd0;
    mem_wstrb_d     = 4'b0000;
    mem_rdata_ack_d = 1'b0;
    cnt_load_d      = cnt_load_q;
    cnt_store_d     = cnt_store_q;
    cnt_stall_d     = cnt_stall_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          op_d        = req_op;
          addr_lo_d   = req_addr[1:0];
          rt_d        = req_rt;
          if (acc_err) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_read_d  = is_load(req_op);
            mem_write_d = is_store(req_op);
            mem_wdata_d = al_wdata;
            mem_wstrb_d = al_wstrb;
          end
        end
      end
      ST_REQ: begin
        cnt_stall_d = cnt_stall_q + CNT_W'(1);
        if (mem_req_ack) begin
          if (mem_read_q) begin
            state_d         = ST_RESP;
            mem_rdata_ack_d = 1'b1;
          end else begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
          end
        end else begin
          mem_addr_d  = mem_addr_q;
          mem_read_d  = mem_read_q;
          mem_write_d = mem_write_q;
          mem_wdata_d = mem_wdata_q;
          mem_wstrb_d = mem_wstrb_q;
        end
      end
      ST_RESP: begin
        cnt_stall_d = cnt_stall_q + CNT_W'(1);
        if (mem_rdata_valid) begin
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = al_load_data;
        end else begin
          mem_rdata_ack_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        if (!resp_err_q) begin
          if (is_load(op_q)) begin
            cnt_load_d = cnt_load_q + CNT_W'(1);
          end else begin
            cnt_store_d = cnt_store_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      op_q            <= 4'd0;
      addr_lo_q       <= 2'd0;
      rt_q            <= 32'd0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= 32'd0;
      resp_err_q      <= 1'b0;
      mem_addr_q      <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_wdata_q     <= 32'd0;
      mem_wstrb_q     <= 4'b0000;
      mem_rdata_ack_q <= 1'b0;
      cnt_load_q      <= '0;
      cnt_store_q     <= '0;
      cnt_stall_q     <= '0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      addr_lo_q       <= addr_lo_d;
      rt_q            <= rt_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_err_q      <= resp_err_d;
      mem_addr_q      <= mem_addr_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      mem_rdata_ack_q <= mem_rdata_ack_d;
      cnt_load_q      <= cnt_load_d;
      cnt_store_q     <= cnt_store_d;
      cnt_stall_q     <= cnt_stall_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign mem_rdata_ack = mem_rdata_ack_q;
  assign cnt_load      = cnt_load_q;
  assign cnt_store     = cnt_store_q;
  assign cnt_stall     = cnt_stall_q;

endmodule
